seq_det_param: RTL and testbench

Parametrised serial sequence detector. It compares a bit stream against a runtime-loadable pattern of `PAT_W` bits, in either overlapping or non-overlapping mode, and counts matches. It replaces the fixed-pattern, 4-bit, always-overlapping `seq_det` at the same place in the design: a serial input sampled on the rising clock edge, with a single-cycle detect output. It adds a data-valid qualifier, pattern load, a mode select and a saturating match counter.

---
 rtl/seq_det_param.sv | 83 ++++++++
 tb/tb_seq_det_param.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_param.sv
// seq_det_param: serial detector for a runtime-loadable PAT_W-bit pattern,
// with overlapping/non-overlapping modes and a saturating match counter.
module seq_det_param #(
  parameter int               PAT_W     = 4,
  parameter int               CNT_W     = 8,
  parameter logic [PAT_W-1:0] PAT_RESET = 4'b1011
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         din,
  input  logic                         din_valid,
  input  logic                         overlap,
  input  logic                         load,
  input  logic [PAT_W-1:0]             pattern_in,
  input  logic                         count_clr,
  output logic                         dout,
  output logic [CNT_W-1:0]             match_count,
  output logic [$clog2(PAT_W+1)-1:0]   present_state
);

  localparam int              ST_W = $clog2(PAT_W+1);
  localparam logic [ST_W-1:0] FULL = ST_W'(PAT_W);

  logic [PAT_W-1:0] r_pat;
  logic [PAT_W-1:0] r_hist;
  logic [ST_W-1:0]  r_state;
  logic             r_dout;
  logic [CNT_W-1:0] r_cnt;

  logic [PAT_W-1:0] w_hist_n;
  logic [ST_W-1:0]  w_fill_n;
  logic             w_match;

  // Next history and fill level; the fill gate keeps a cleared history from matching.
  always_comb begin
    w_hist_n = {r_hist[PAT_W-2:0], din};
    if (r_state == FULL) begin
      w_fill_n = FULL;
    end else begin
      w_fill_n = r_state + {{(ST_W-1){1'b0}}, 1'b1};
    end
    w_match = (!load) && din_valid && (w_fill_n == FULL) && (w_hist_n == r_pat);
  end

  // Pattern, history, fill level and detect pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pat   <= PAT_RESET;
      r_hist  <= '0;
      r_state <= '0;
      r_dout  <= 1'b0;
    end else if (load) begin
      r_pat   <= pattern_in;
      r_hist  <= '0;
      r_state <= '0;
      r_dout  <= 1'b0;
    end else if (din_valid) begin
      r_hist  <= w_hist_n;
      r_dout  <= w_match;
      r_state <= (w_match && !overlap) ? '0 : w_fill_n;
    end else begin
      r_dout  <= 1'b0;
    end
  end

  // Match counter: clear beats a coincident match, increments stick at all ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (count_clr) begin
      r_cnt <= '0;
    end else if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign dout          = r_dout;
  assign match_count   = r_cnt;
  assign present_state = r_state;

endmodule

// File: tb/tb_seq_det_param.sv
// Bench for seq_det_param: directed vector table, hand-written corner cases and
// randomized traffic checked against a queue-based reference model.
module tb_seq_det_param;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       din = 1'b0, din_valid = 1'b0, overlap = 1'b1, load = 1'b0, count_clr = 1'b0;
  logic [3:0] pattern_in = 4'b0000;
  logic       dout;
  logic [7:0] match_count;
  logic [2:0] present_state;

  logic       b_din = 1'b0, b_valid = 1'b0, b_ov = 1'b1, b_load = 1'b0, b_clr = 1'b0;
  logic [1:0] b_pin = 2'b00;
  logic       b_dout;
  logic [1:0] b_cnt;
  logic [1:0] b_state;

  int nvec = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  seq_det_param u1 (
    .clock(clock), .reset(reset), .din(din), .din_valid(din_valid), .overlap(overlap),
    .load(load), .pattern_in(pattern_in), .count_clr(count_clr), .dout(dout),
    .match_count(match_count), .present_state(present_state)
  );

  seq_det_param #(.PAT_W(2), .CNT_W(2), .PAT_RESET(2'b11)) u2 (
    .clock(clock), .reset(reset), .din(b_din), .din_valid(b_valid), .overlap(b_ov),
    .load(b_load), .pattern_in(b_pin), .count_clr(b_clr), .dout(b_dout),
    .match_count(b_cnt), .present_state(b_state)
  );

  typedef struct {
    logic       ld;
    logic [3:0] p;
    logic       v;
    logic       d;
    logic       ov;
    logic       clr;
    logic       ed;
    logic [7:0] ec;
    logic [2:0] es;
  } vec_t;

  vec_t tbl[$];

  // Reference model: the bits received since the last reset/load/non-overlap match.
  logic       mq[$];
  logic [3:0] mpat;
  int         mcnt;
  logic       mdout;

  function automatic vec_t mk(input logic ld, input logic [3:0] p, input logic v, input logic d,
                              input logic ov, input logic clr, input logic ed,
                              input logic [7:0] ec, input logic [2:0] es);
    vec_t t;
    t.ld = ld; t.p = p; t.v = v; t.d = d; t.ov = ov; t.clr = clr;
    t.ed = ed; t.ec = ec; t.es = es;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpat  = 4'b1011;
    mcnt  = 0;
    mdout = 1'b0;
  endtask

  task automatic model_step(input logic ld, input logic [3:0] p, input logic v, input logic d,
                            input logic ov, input logic clr);
    logic m;
    m = 1'b0;
    if (ld) begin
      mpat = p;
      mq.delete();
      mdout = 1'b0;
    end else if (v) begin
      mq.push_back(d);
      if (mq.size() > 4) void'(mq.pop_front());
      if (mq.size() == 4) begin
        m = 1'b1;
        for (int i = 0; i < 4; i++) if (mq[i] != mpat[3-i]) m = 1'b0;
      end
      mdout = m;
      if (m && !ov) mq.delete();
    end else begin
      mdout = 1'b0;
    end
    if (clr) mcnt = 0;
    else if (m && mcnt < 255) mcnt++;
  endtask

  task automatic step(input vec_t t);
    @(negedge clock);
    load = t.ld; pattern_in = t.p; din_valid = t.v; din = t.d; overlap = t.ov; count_clr = t.clr;
    model_step(t.ld, t.p, t.v, t.d, t.ov, t.clr);
    @(posedge clock);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".dout"},  32'(dout),          32'(mdout));
    chk({tag, ".count"}, 32'(match_count),   32'(mcnt));
    chk({tag, ".state"}, 32'(present_state), 32'(mq.size()));
  endtask

  task automatic bstep(input logic v, input logic d, input logic clr);
    @(negedge clock);
    b_valid = v; b_din = d; b_clr = clr;
    @(posedge clock);
    #1;
  endtask

  initial begin
    vec_t t;
    logic [3:0] rp;
    logic       rov;

    // Test 1: overlap, default pattern 1011
    tbl.push_back(mk(0, 4'h0, 1, 1, 1, 0, 0, 8'd0, 3'd1));
    tbl.push_back(mk(0, 4'h0, 1, 0, 1, 0, 0, 8'd0, 3'd2));
    tbl.push_back(mk(0, 4'h0, 1, 1, 1, 0, 0, 8'd0, 3'd3));
    tbl.push_back(mk(0, 4'h0, 1, 1, 1, 0, 1, 8'd1, 3'd4));
    tbl.push_back(mk(0, 4'h0, 1, 0, 1, 0, 0, 8'd1, 3'd4));
    tbl.push_back(mk(0, 4'h0, 1, 1, 1, 0, 0, 8'd1, 3'd4));
    tbl.push_back(mk(0, 4'h0, 1, 1, 1, 0, 1, 8'd2, 3'd4));
    // Test 2: non-overlap after reload + clear
    tbl.push_back(mk(1, 4'hB, 0, 0, 0, 1, 0, 8'd0, 3'd0));
    tbl.push_back(mk(0, 4'h0, 1, 1, 0, 0, 0, 8'd0, 3'd1));
    tbl.push_back(mk(0, 4'h0, 1, 0, 0, 0, 0, 8'd0, 3'd2));
    tbl.push_back(mk(0, 4'h0, 1, 1, 0, 0, 0, 8'd0, 3'd3));
    tbl.push_back(mk(0, 4'h0, 1, 1, 0, 0, 1, 8'd1, 3'd0));
    tbl.push_back(mk(0, 4'h0, 1, 0, 0, 0, 0, 8'd1, 3'd1));
    tbl.push_back(mk(0, 4'h0, 1, 1, 0, 0, 0, 8'd1, 3'd2));
    tbl.push_back(mk(0, 4'h0, 1, 1, 0, 0, 0, 8'd1, 3'd3));
    // Test 3: all-zero pattern, load ignores a coincident valid bit
    tbl.push_back(mk(1, 4'h0, 1, 1, 1, 0, 0, 8'd1, 3'd0));
    tbl.push_back(mk(0, 4'h0, 1, 0, 1, 0, 0, 8'd1, 3'd1));
    tbl.push_back(mk(0, 4'h0, 1, 0, 1, 0, 0, 8'd1, 3'd2));
    tbl.push_back(mk(0, 4'h0, 1, 0, 1, 0, 0, 8'd1, 3'd3));
    tbl.push_back(mk(0, 4'h0, 1, 0, 1, 0, 1, 8'd2, 3'd4));
    tbl.push_back(mk(0, 4'h0, 1, 0, 1, 0, 1, 8'd3, 3'd4));
    // Test 4: valid gaps with toggling din
    tbl.push_back(mk(1, 4'hB, 0, 0, 1, 1, 0, 8'd0, 3'd0));
    tbl.push_back(mk(0, 4'h0, 1, 1, 1, 0, 0, 8'd0, 3'd1));
    tbl.push_back(mk(0, 4'h0, 0, 0, 1, 0, 0, 8'd0, 3'd1));
    tbl.push_back(mk(0, 4'h0, 0, 1, 1, 0, 0, 8'd0, 3'd1));
    tbl.push_back(mk(0, 4'h0, 1, 0, 1, 0, 0, 8'd0, 3'd2));
    tbl.push_back(mk(0, 4'h0, 0, 1, 1, 0, 0, 8'd0, 3'd2));
    tbl.push_back(mk(0, 4'h0, 1, 1, 1, 0, 0, 8'd0, 3'd3));
    tbl.push_back(mk(0, 4'h0, 0, 0, 1, 0, 0, 8'd0, 3'd3));
    tbl.push_back(mk(0, 4'h0, 1, 1, 1, 0, 1, 8'd1, 3'd4));
    tbl.push_back(mk(0, 4'h0, 0, 1, 1, 0, 0, 8'd1, 3'd4));

    model_reset();
    #1;
    chk("rst.dout",   32'(dout),          32'd0);
    chk("rst.count",  32'(match_count),   32'd0);
    chk("rst.state",  32'(present_state), 32'd0);
    chk("rst.b_cnt",  32'(b_cnt),         32'd0);
    chk("rst.b_state", 32'(b_state),      32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i]);
      chk($sformatf("tbl%0d.dout", i),  32'(dout),          32'(tbl[i].ed));
      chk($sformatf("tbl%0d.count", i), 32'(match_count),   32'(tbl[i].ec));
      chk($sformatf("tbl%0d.state", i), 32'(present_state), 32'(tbl[i].es));
    end

    // Test 5: asynchronous reset mid-sequence
    step(mk(1, 4'hB, 0, 0, 1, 0, 0, 8'd0, 3'd0));
    step(mk(0, 4'h0, 1, 1, 1, 0, 0, 8'd0, 3'd0));
    step(mk(0, 4'h0, 1, 0, 1, 0, 0, 8'd0, 3'd0));
    step(mk(0, 4'h0, 1, 1, 1, 0, 0, 8'd0, 3'd0));
    chk("rstmid.pre_state", 32'(present_state), 32'd3);
    @(negedge clock);
    din_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rstmid.state", 32'(present_state), 32'd0);
    chk("rstmid.dout",  32'(dout),          32'd0);
    chk("rstmid.count", 32'(match_count),   32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    step(mk(0, 4'h0, 1, 1, 1, 0, 0, 8'd0, 3'd0));
    chk("rstmid.post_dout",  32'(dout),          32'd0);
    chk("rstmid.post_state", 32'(present_state), 32'd1);
    chk("rstmid.post_count", 32'(match_count),   32'd0);

    // Randomized traffic against the reference model
    rp  = 4'b1011;
    rov = 1'b1;
    for (int n = 0; n < 800; n++) begin
      t = mk(0, 4'h0, 0, 0, rov, 0, 0, 8'd0, 3'd0);
      if ($urandom_range(0, 29) == 0) begin
        t.ld = 1'b1;
        rp   = 4'($urandom_range(0, 15));
        t.p  = rp;
      end
      if ($urandom_range(0, 15) == 0) rov = ~rov;
      t.ov  = rov;
      t.v   = ($urandom_range(0, 3) != 0);
      t.d   = 1'($urandom_range(0, 1));
      t.clr = ($urandom_range(0, 49) == 0);
      step(t);
      check_model("rand");
    end

    // Test 6: 2-bit counter saturation and clear priority on the small instance
    bstep(1'b1, 1'b1, 1'b0);
    chk("sat.b1.dout",  32'(b_dout),  32'd0);
    chk("sat.b1.state", 32'(b_state), 32'd1);
    chk("sat.b1.count", 32'(b_cnt),   32'd0);
    for (int k = 2; k <= 6; k++) begin
      bstep(1'b1, 1'b1, 1'b0);
      chk($sformatf("sat.b%0d.dout", k),  32'(b_dout), 32'd1);
      chk($sformatf("sat.b%0d.count", k), 32'(b_cnt),  32'((k - 1 > 3) ? 3 : k - 1));
    end
    bstep(1'b1, 1'b1, 1'b1);
    chk("sat.clr.dout",  32'(b_dout), 32'd1);
    chk("sat.clr.count", 32'(b_cnt),  32'd0);
    bstep(1'b0, 1'b0, 1'b0);
    chk("sat.idle.dout",  32'(b_dout), 32'd0);
    chk("sat.idle.count", 32'(b_cnt),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
